// File: rtl/eth_pkt_fifo_if.sv
// Frame-stream bus for eth_pkt_fifo: input beats, output beats with
// downstream ready, and the drop/queue status counters.
interface eth_pkt_fifo_if #(
    parameter int P_DATA_W    = 8,
    parameter int P_PKT_DEPTH = 16
);
    localparam int CW = $clog2(P_PKT_DEPTH) + 1;

    logic [P_DATA_W-1:0] i_data;
    logic                i_valid;
    logic                i_last;
    logic                i_err;
    logic [P_DATA_W-1:0] o_data;
    logic                o_valid;
    logic                o_last;
    logic                i_ready;
    logic [15:0]         o_drop_cnt;
    logic [CW-1:0]       o_pkt_cnt;

    modport master (
        output i_data, i_valid, i_last, i_err, i_ready,
        input  o_data, o_valid, o_last, o_drop_cnt, o_pkt_cnt
    );

    modport slave (
        input  i_data, i_valid, i_last, i_err, i_ready,
        output o_data, o_valid, o_last, o_drop_cnt, o_pkt_cnt
    );
endinterface

// File: rtl/eth_pkt_fifo.sv
// Store-and-forward Ethernet frame buffer: committed-length queue,
// per-frame drop with pointer rewind, output backpressure, inter-frame gap.
module eth_pkt_fifo #(
    parameter int P_DATA_W    = 8,
    parameter int P_DEPTH     = 4096,
    parameter int P_PKT_DEPTH = 16,
    parameter int P_GAP       = 4
) (
    input logic           i_clk,
    input logic           i_rst,
    eth_pkt_fifo_if.slave bus
);
    localparam int AW = $clog2(P_DEPTH);
    localparam int QW = $clog2(P_PKT_DEPTH);
    localparam int CW = QW + 1;
    localparam int GW = $clog2(P_GAP + 1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(P_DEPTH);
    localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);
    localparam logic [AW:0] LEN_TWO  = (AW+1)'(2);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, GAP} state_t;

    logic [P_DATA_W-1:0] mem [P_DEPTH];
    logic [AW:0]         lq  [P_PKT_DEPTH];

    logic [AW:0]         wr_ptr;
    logic [AW:0]         cm_ptr;
    logic [AW:0]         rd_ptr;
    logic [AW:0]         rd_nxt;
    logic [AW:0]         rem;
    logic [QW:0]         lq_wp;
    logic [QW:0]         lq_rp;
    logic                in_frame;
    logic                dropping;
    logic [15:0]         drop_cnt;
    logic [CW-1:0]       pkt_cnt;
    state_t              state;
    logic [GW-1:0]       gap_cnt;
    logic [P_DATA_W-1:0] data_q;
    logic                valid_q;
    logic                last_q;

    logic frame_start;
    logic pkt_full;
    logic ram_full;
    logic drop_now;
    logic wr_beat;
    logic commit;
    logic xfer;
    logic done;
    logic lq_empty;

    // Full tests use the pre-edge rd_ptr, so space freed this cycle counts next cycle.
    always_comb begin
        frame_start = bus.i_valid & ~in_frame;
        pkt_full    = pkt_cnt == CW'(P_PKT_DEPTH);
        ram_full    = (wr_ptr - rd_ptr) == FULL_LVL;
        drop_now    = dropping | (frame_start & pkt_full) | ram_full;
        wr_beat     = bus.i_valid & ~drop_now;
        commit      = bus.i_valid & bus.i_last & ~drop_now & ~bus.i_err;
        xfer        = valid_q & bus.i_ready;
        done        = xfer & last_q;
        lq_empty    = lq_wp == lq_rp;
        rd_nxt      = rd_ptr + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (wr_beat)
            mem[wr_ptr[AW-1:0]] <= bus.i_data;
    end

    always_ff @(posedge i_clk) begin
        if (commit)
            lq[lq_wp[QW-1:0]] <= wr_ptr + 1'b1 - cm_ptr;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            lq_wp    <= '0;
            in_frame <= 1'b0;
            dropping <= 1'b0;
            drop_cnt <= '0;
        end else if (bus.i_valid) begin
            if (bus.i_last) begin
                in_frame <= 1'b0;
                dropping <= 1'b0;
                if (commit) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    cm_ptr <= wr_ptr + 1'b1;
                    lq_wp  <= lq_wp + 1'b1;
                end else begin
                    wr_ptr <= cm_ptr;
                    if (drop_cnt != '1)
                        drop_cnt <= drop_cnt + 1'b1;
                end
            end else begin
                in_frame <= 1'b1;
                dropping <= drop_now;
                if (wr_beat)
                    wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Counts frames from commit until their last beat leaves, not until pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            pkt_cnt <= '0;
        else if (commit & ~done)
            pkt_cnt <= pkt_cnt + 1'b1;
        else if (done & ~commit)
            pkt_cnt <= pkt_cnt - 1'b1;
    end

    // data_q doubles as the prefetch register: the next beat is read on each transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            rem     <= '0;
            lq_rp   <= '0;
            gap_cnt <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!lq_empty) begin
                        rem   <= lq[lq_rp[QW-1:0]];
                        lq_rp <= lq_rp + 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    data_q  <= mem[rd_ptr[AW-1:0]];
                    valid_q <= 1'b1;
                    last_q  <= rem == LEN_ONE;
                    state   <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        rd_ptr <= rd_nxt;
                        rem    <= rem - 1'b1;
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            data_q <= mem[rd_nxt[AW-1:0]];
                            last_q <= rem == LEN_TWO;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(P_GAP - 1))
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_last     = last_q;
    assign bus.o_drop_cnt = drop_cnt;
    assign bus.o_pkt_cnt  = pkt_cnt;
endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Scoreboard bench for eth_pkt_fifo: a large instance (wrap, gap, backpressure)
// and a small one (overflow, queue full).
module tb_eth_pkt_fifo;
    localparam int GAP = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    eth_pkt_fifo_if #(.P_DATA_W(8), .P_PKT_DEPTH(16)) ba ();
    eth_pkt_fifo_if #(.P_DATA_W(8), .P_PKT_DEPTH(4))  bb ();

    eth_pkt_fifo #(
        .P_DATA_W(8), .P_DEPTH(4096), .P_PKT_DEPTH(16), .P_GAP(GAP)
    ) dut_a (.i_clk(i_clk), .i_rst(i_rst), .bus(ba));

    eth_pkt_fifo #(
        .P_DATA_W(8), .P_DEPTH(16), .P_PKT_DEPTH(4), .P_GAP(GAP)
    ) dut_b (.i_clk(i_clk), .i_rst(i_rst), .bus(bb));

    logic [7:0] d;
    logic       v, l, e;
    logic       rdy_a, rdy_b;
    int         sel;

    assign ba.i_data  = d;
    assign ba.i_valid = v && sel == 0;
    assign ba.i_last  = l;
    assign ba.i_err   = e;
    assign ba.i_ready = rdy_a;
    assign bb.i_data  = d;
    assign bb.i_valid = v && sel == 1;
    assign bb.i_last  = l;
    assign bb.i_err   = e;
    assign bb.i_ready = rdy_b;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    beat_t qa[$];
    beat_t qb[$];
    int    lat_t;
    bit    lat_arm;
    bit    stop;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic no_exp(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h want none", name, act);
    endtask

    // Monitor A: data, stall stability, inter-frame gap and first-frame latency.
    bit    a_stall, a_pv, a_seen_last;
    int    a_low;
    beat_t a_hold;
    always @(negedge i_clk) begin
        beat_t cur;
        beat_t ex;
        cur = {ba.o_data, ba.o_last};
        if (i_rst) begin
            a_stall = 0; a_pv = 0; a_seen_last = 0; a_low = 0;
        end else begin
            if (a_stall) begin
                chk("a_hold_valid", 32'(ba.o_valid), 32'd1);
                chk("a_hold_beat", 32'(cur), 32'(a_hold));
            end
            if (!ba.o_valid)
                a_low++;
            else if (!a_pv) begin
                if (a_seen_last)
                    chk("a_gap", 32'(a_low >= GAP + 2), 32'd1);
                if (lat_arm) begin
                    chk("a_latency", 32'(cyc - lat_t), 32'd2);
                    lat_arm = 0;
                end
            end
            if (ba.o_valid && ba.i_ready) begin
                if (qa.size() == 0)
                    no_exp("a_extra_beat", 32'(cur));
                else begin
                    ex = qa.pop_front();
                    chk("a_beat", 32'(cur), 32'(ex));
                end
                if (ba.o_last) begin
                    a_seen_last = 1;
                    a_low = 0;
                end
            end
            a_stall = ba.o_valid && !ba.i_ready;
            a_hold  = cur;
            a_pv    = ba.o_valid;
        end
    end

    // Monitor B: data and stall stability.
    bit    b_stall;
    beat_t b_hold;
    always @(negedge i_clk) begin
        beat_t cur;
        beat_t ex;
        cur = {bb.o_data, bb.o_last};
        if (i_rst)
            b_stall = 0;
        else begin
            if (b_stall)
                chk("b_hold_beat", 32'({bb.o_valid, cur}), 32'({1'b1, b_hold}));
            if (bb.o_valid && bb.i_ready) begin
                if (qb.size() == 0)
                    no_exp("b_extra_beat", 32'(cur));
                else begin
                    ex = qb.pop_front();
                    chk("b_beat", 32'(cur), 32'(ex));
                end
            end
            b_stall = bb.o_valid && !bb.i_ready;
            b_hold  = cur;
        end
    end

    task automatic send(input int s, input int len, input int base,
                        input bit err, input bit ok, input bit fin);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            @(posedge i_clk); #1;
            sel = s;
            v   = 1'b1;
            d   = 8'(base + i);
            l   = fin && i == len - 1;
            e   = err && i == len - 1;
            b.d = d;
            b.l = l;
            if (ok) begin
                if (s == 0) qa.push_back(b);
                else        qb.push_back(b);
            end
        end
    endtask

    task automatic idle();
        @(posedge i_clk); #1;
        v = 1'b0; l = 1'b0; e = 1'b0;
    endtask

    task automatic drain(input int s, input int budget);
        int n;
        n = 0;
        while ((s == 0 ? qa.size() : qb.size()) != 0 && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        chk(s == 0 ? "a_drain" : "b_drain",
            32'(s == 0 ? qa.size() : qb.size()), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    initial begin
        d = '0; v = 0; l = 0; e = 0; sel = 0;
        rdy_a = 1; rdy_b = 0; lat_arm = 0; stop = 0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_a_data", 32'(ba.o_data), 32'd0);
        chk("rst_a_valid", 32'(ba.o_valid), 32'd0);
        chk("rst_a_last", 32'(ba.o_last), 32'd0);
        chk("rst_a_drop", 32'(ba.o_drop_cnt), 32'd0);
        chk("rst_a_pkt", 32'(ba.o_pkt_cnt), 32'd0);
        chk("rst_b_valid", 32'(bb.o_valid), 32'd0);
        chk("rst_b_pkt", 32'(bb.o_pkt_cnt), 32'd0);
        i_rst = 0;

        // single 64-beat frame
        send(0, 64, 0, 0, 1, 1);
        idle();
        chk("single_pkt_1", 32'(ba.o_pkt_cnt), 32'd1);
        lat_t = cyc;
        lat_arm = 1;
        drain(0, 500);
        chk("single_pkt_0", 32'(ba.o_pkt_cnt), 32'd0);
        chk("single_lat_seen", 32'(lat_arm), 32'd0);

        // error frame then good frame
        send(0, 10, 8'h80, 1, 0, 1);
        send(0, 5, 8'hA0, 0, 1, 1);
        idle();
        drain(0, 200);
        chk("err_drop", 32'(ba.o_drop_cnt), 32'd1);
        chk("err_pkt", 32'(ba.o_pkt_cnt), 32'd0);

        // overflow on the 16-deep instance
        rdy_b = 0;
        send(1, 12, 8'h10, 0, 1, 1);
        send(1, 10, 8'h40, 0, 0, 1);
        idle();
        chk("ovf_drop", 32'(bb.o_drop_cnt), 32'd1);
        chk("ovf_pkt", 32'(bb.o_pkt_cnt), 32'd1);
        rdy_b = 1;
        drain(1, 200);
        chk("ovf_pkt_0", 32'(bb.o_pkt_cnt), 32'd0);
        send(1, 3, 8'hE0, 0, 1, 1);
        idle();
        drain(1, 100);

        // length queue full
        rdy_b = 0;
        for (int k = 0; k < 5; k++)
            send(1, 2, 8'hC0 + 2 * k, 0, k < 4, 1);
        idle();
        chk("qfull_pkt", 32'(bb.o_pkt_cnt), 32'd4);
        chk("qfull_drop", 32'(bb.o_drop_cnt), 32'd2);
        rdy_b = 1;
        drain(1, 200);
        chk("qfull_pkt_0", 32'(bb.o_pkt_cnt), 32'd0);

        // backpressure with random ready over 1, 2, 300-beat frames
        fork
            begin
                send(0, 1, 8'h01, 0, 1, 1);
                send(0, 2, 8'h11, 0, 1, 1);
                send(0, 300, 8'h20, 0, 1, 1);
                idle();
                drain(0, 5000);
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge i_clk); #1;
                    rdy_a = 1'($urandom_range(0, 1));
                end
            end
        join
        rdy_a = 1;
        chk("bp_pkt_0", 32'(ba.o_pkt_cnt), 32'd0);

        // pointer wrap: 20 x 1000 beats
        for (int f = 0; f < 20; f++)
            send(0, 1000, f * 13, 0, 1, 1);
        idle();
        drain(0, 30000);
        chk("wrap_drop", 32'(ba.o_drop_cnt), 32'd1);
        chk("wrap_pkt", 32'(ba.o_pkt_cnt), 32'd0);

        // reset with a queued frame and a partial frame in flight
        rdy_a = 0;
        send(0, 4, 8'h55, 0, 0, 1);
        send(0, 20, 8'h60, 0, 0, 0);
        chk("pre_rst_valid", 32'(ba.o_valid), 32'd1);
        chk("pre_rst_data", 32'(ba.o_data), 32'h55);
        #2;
        i_rst = 1;
        v = 0; l = 0; e = 0;
        #1;
        chk("mid_rst_data", 32'(ba.o_data), 32'd0);
        chk("mid_rst_valid", 32'(ba.o_valid), 32'd0);
        chk("mid_rst_last", 32'(ba.o_last), 32'd0);
        chk("mid_rst_drop", 32'(ba.o_drop_cnt), 32'd0);
        chk("mid_rst_pkt", 32'(ba.o_pkt_cnt), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 0;
        rdy_a = 1;
        send(0, 3, 8'h33, 0, 1, 1);
        idle();
        drain(0, 100);
        chk("post_rst_drop", 32'(ba.o_drop_cnt), 32'd0);
        chk("post_rst_pkt", 32'(ba.o_pkt_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
